fp_result_queue: RTL and testbench

- Downstream stage of the floating-point adder/subtractor.
- Captures each IEEE-754 single-precision result word and its exception bit.
- Classifies each result as zero, infinity, NaN or denormal and buffers it in a small FIFO.
- Hands results to the consumer over a valid/ready handshake, and keeps a sticky overflow flag and a saturating exception counter for software/debug.

---
 rtl/fp_pkg.sv | 26 ++
 rtl/fp_result_queue_if.sv | 25 ++
 rtl/fp_classify.sv | 29 ++
 rtl/fp_result_queue.sv | 113 +++++++++++
 tb/tb_fp_result_queue.sv | 232 +++++++++++++++++++++++
 5 files changed

// File: rtl/fp_pkg.sv
// Shared IEEE-754 single-precision field positions, flag layout and
// queue entry payload for the floating-point pipeline stages.
package fp_pkg;

  localparam int unsigned WORD_W   = 32;
  localparam int unsigned SIGN_BIT = 31;
  localparam int unsigned EXP_MSB  = 30;
  localparam int unsigned EXP_LSB  = 23;
  localparam int unsigned MANT_MSB = 22;
  localparam int unsigned EXP_W    = EXP_MSB - EXP_LSB + 1;

  localparam logic [EXP_W-1:0] EXP_MAX = 8'hFF;

  localparam int unsigned FLG_EXC  = 0;
  localparam int unsigned FLG_ZERO = 1;
  localparam int unsigned FLG_INF  = 2;
  localparam int unsigned FLG_NAN  = 3;
  localparam int unsigned FLG_DEN  = 4;
  localparam int unsigned FLAG_W   = 5;

  typedef struct packed {
    logic [WORD_W-1:0] data;
    logic [FLAG_W-1:0] flags;
  } fp_entry_t;

endpackage

// File: rtl/fp_result_queue_if.sv
// Producer/consumer handshake bundle of the result queue; the queue
// itself uses the slave view, the surrounding pipeline the master view.
interface fp_result_queue_if;
  import fp_pkg::*;

  logic              in_valid;
  logic [WORD_W-1:0] in_data;
  logic              in_exception;
  logic              in_ready;
  logic              out_valid;
  logic [WORD_W-1:0] out_data;
  logic [FLAG_W-1:0] out_flags;
  logic              out_ready;

  modport master (
    output in_valid, in_data, in_exception, out_ready,
    input  in_ready, out_valid, out_data, out_flags
  );

  modport slave (
    input  in_valid, in_data, in_exception, out_ready,
    output in_ready, out_valid, out_data, out_flags
  );

endinterface

// File: rtl/fp_classify.sv
// Combinational IEEE-754 single-precision classifier: zero, infinity,
// NaN or denormal; normal numbers raise none of the four flags.
module fp_classify
  import fp_pkg::*;
(
  input  logic [WORD_W-1:0] i_word,
  output logic              o_zero,
  output logic              o_inf,
  output logic              o_nan,
  output logic              o_den
);

  logic [EXP_W-1:0]  w_exp;
  logic [MANT_MSB:0] w_mant;
  logic              w_mant_nz;
  logic              w_unused_sign;

  assign w_exp         = i_word[EXP_MSB:EXP_LSB];
  assign w_mant        = i_word[MANT_MSB:0];
  assign w_mant_nz     = |w_mant;
  // Sign never changes the class of a value.
  assign w_unused_sign = i_word[SIGN_BIT];

  assign o_zero = (w_exp == '0)      & ~w_mant_nz;
  assign o_den  = (w_exp == '0)      &  w_mant_nz;
  assign o_inf  = (w_exp == EXP_MAX) & ~w_mant_nz;
  assign o_nan  = (w_exp == EXP_MAX) &  w_mant_nz;

endmodule

// File: rtl/fp_result_queue.sv
// Result FIFO behind the FP adder: classifies and buffers each result,
// keeps a sticky overflow flag and a saturating exception counter.
module fp_result_queue
  import fp_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CNT_W = 8
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  fp_result_queue_if.slave        io_q,
  input  logic                    i_clear_stats,
  output logic [$clog2(DEPTH):0]  o_count,
  output logic                    o_overflow,
  output logic [CNT_W-1:0]        o_exc_count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned OCC_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] EXC_MAX = '1;

  fp_entry_t         r_mem [DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [OCC_W-1:0]  r_count;
  logic              r_overflow;
  logic [CNT_W-1:0]  r_exc_count;

  logic              w_in_ready;
  logic              w_out_valid;
  logic              w_push;
  logic              w_pop;
  logic              w_zero;
  logic              w_inf;
  logic              w_nan;
  logic              w_den;
  logic [FLAG_W-1:0] w_flags;
  fp_entry_t         w_head;

  fp_classify u_classify (
    .i_word (io_q.in_data),
    .o_zero (w_zero),
    .o_inf  (w_inf),
    .o_nan  (w_nan),
    .o_den  (w_den)
  );

  // Handshake depends on registered occupancy only.
  assign w_in_ready  = (r_count != OCC_W'(DEPTH));
  assign w_out_valid = (r_count != '0);
  assign w_push      = io_q.in_valid & w_in_ready;
  assign w_pop       = w_out_valid & io_q.out_ready;

  always_comb begin
    w_flags           = '0;
    w_flags[FLG_EXC]  = io_q.in_exception;
    w_flags[FLG_ZERO] = w_zero;
    w_flags[FLG_INF]  = w_inf;
    w_flags[FLG_NAN]  = w_nan;
    w_flags[FLG_DEN]  = w_den;
  end

  // Storage is deliberately left out of reset.
  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= '{data: io_q.in_data, flags: w_flags};
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + OCC_W'(1);
        2'b01:   r_count <= r_count - OCC_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Clear beats any coinciding overflow or exception event.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_overflow  <= 1'b0;
      r_exc_count <= '0;
    end else if (i_clear_stats) begin
      r_overflow  <= 1'b0;
      r_exc_count <= '0;
    end else begin
      if (io_q.in_valid & ~w_in_ready) r_overflow <= 1'b1;
      if (w_push & io_q.in_exception & (r_exc_count != EXC_MAX)) begin
        r_exc_count <= r_exc_count + CNT_W'(1);
      end
    end
  end

  assign w_head = r_mem[r_rd_ptr];

  assign io_q.in_ready  = w_in_ready;
  assign io_q.out_valid = w_out_valid;
  assign io_q.out_data  = w_out_valid ? w_head.data  : '0;
  assign io_q.out_flags = w_out_valid ? w_head.flags : '0;

  assign o_count     = r_count;
  assign o_overflow  = r_overflow;
  assign o_exc_count = r_exc_count;

endmodule

// File: tb/tb_fp_result_queue.sv
// Directed bench for fp_result_queue: a queue-based reference model checked
// every cycle, plus literal expectations at each scenario's key points.
module tb_fp_result_queue;
  import fp_pkg::*;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned CNT_W = 2;
  localparam int unsigned EXC_SAT = (1 << CNT_W) - 1;

  logic                    clk = 1'b0;
  logic                    rst = 1'b0;
  logic                    clear_stats = 1'b0;
  logic [$clog2(DEPTH):0]  count;
  logic                    overflow;
  logic [CNT_W-1:0]        exc_count;

  int n_chk  = 0;
  int n_fail = 0;
  bit cmp_en = 1'b0;

  fp_entry_t m_q[$];
  int        m_ovf = 0;
  int        m_exc = 0;

  fp_result_queue_if bus ();

  fp_result_queue #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .io_q          (bus),
    .i_clear_stats (clear_stats),
    .o_count       (count),
    .o_overflow    (overflow),
    .o_exc_count   (exc_count)
  );

  always #5 clk = ~clk;

  function automatic logic [FLAG_W-1:0] ref_flags(input logic [31:0] w, input logic exc);
    int e;
    int m;
    logic [FLAG_W-1:0] f;
    e = int'(w[30:23]);
    m = int'(w[22:0]);
    f = '0;
    f[0] = exc;
    f[1] = (e == 0)   && (m == 0);
    f[2] = (e == 255) && (m == 0);
    f[3] = (e == 255) && (m != 0);
    f[4] = (e == 0)   && (m != 0);
    return f;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: FIFO of entries, sticky overflow, saturating counter.
  initial begin
    fp_entry_t e;
    bit push;
    bit pop;
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        m_q.delete();
        m_ovf = 0;
        m_exc = 0;
      end else begin
        push = bus.in_valid && (m_q.size() < DEPTH);
        pop  = (m_q.size() != 0) && bus.out_ready;
        if (pop) e = m_q.pop_front();
        if (push) m_q.push_back('{data: bus.in_data,
                                  flags: ref_flags(bus.in_data, bus.in_exception)});
        if (clear_stats) begin
          m_ovf = 0;
          m_exc = 0;
        end else begin
          if (bus.in_valid && !push) m_ovf = 1;
          if (push && bus.in_exception && m_exc < EXC_SAT) m_exc++;
        end
      end
    end
  end

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    if (cmp_en) begin
      chk("in_ready",  32'(bus.in_ready),  32'(m_q.size() < DEPTH));
      chk("out_valid", 32'(bus.out_valid), 32'(m_q.size() != 0));
      chk("out_data",  bus.out_data,  (m_q.size() != 0) ? m_q[0].data : 32'h0);
      chk("out_flags", 32'(bus.out_flags), (m_q.size() != 0) ? 32'(m_q[0].flags) : 32'h0);
      chk("count",     32'(count),     32'(m_q.size()));
      chk("overflow",  32'(overflow),  32'(m_ovf));
      chk("exc_count", 32'(exc_count), 32'(m_exc));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] d, input logic x, input logic rdy);
    bus.in_valid     = v;
    bus.in_data      = d;
    bus.in_exception = x;
    bus.out_ready    = rdy;
    step();
    bus.in_valid     = 1'b0;
    bus.in_exception = 1'b0;
    bus.out_ready    = 1'b0;
  endtask

  logic [31:0] t4 [5];

  initial begin
    bus.in_valid     = 1'b0;
    bus.in_data      = '0;
    bus.in_exception = 1'b0;
    bus.out_ready    = 1'b0;
    #1 rst = 1'b1;
    step();
    step();
    #2 rst = 1'b0;
    step();
    cmp_en = 1'b1;
    chk("init_count", 32'(count), 32'd0);
    chk("init_in_ready", 32'(bus.in_ready), 32'd1);

    // 1: build up state, then reset asynchronously with two entries queued
    drive(1, 32'h3F800000, 1, 0);
    drive(1, 32'h40000000, 0, 0);
    drive(1, 32'h40400000, 0, 0);
    drive(1, 32'h40800000, 0, 0);
    drive(1, 32'h40A00000, 0, 0);
    drive(0, 32'h0, 0, 1);
    drive(0, 32'h0, 0, 1);
    chk("t1_pre_count", 32'(count), 32'd2);
    chk("t1_pre_ovf", 32'(overflow), 32'd1);
    #3 rst = 1'b1;
    #1;
    chk("t1_count", 32'(count), 32'd0);
    chk("t1_out_valid", 32'(bus.out_valid), 32'd0);
    chk("t1_out_data", bus.out_data, 32'd0);
    chk("t1_overflow", 32'(overflow), 32'd0);
    chk("t1_exc_count", 32'(exc_count), 32'd0);
    chk("t1_in_ready", 32'(bus.in_ready), 32'd1);
    step();
    #3 rst = 1'b0;
    step();

    // 2: single push, one-cycle latency, then pop
    drive(1, 32'h42C80000, 0, 0);
    chk("t2_out_valid", 32'(bus.out_valid), 32'd1);
    chk("t2_out_data", bus.out_data, 32'h42C80000);
    chk("t2_out_flags", 32'(bus.out_flags), 32'h00);
    chk("t2_count", 32'(count), 32'd1);
    drive(0, 32'h0, 0, 1);
    chk("t2_count_after_pop", 32'(count), 32'd0);

    // 3: classification of special values
    drive(1, 32'h00000000, 0, 0);
    drive(1, 32'h7F800000, 0, 0);
    drive(1, 32'h7FC00000, 0, 0);
    drive(1, 32'h00000001, 1, 0);
    chk("t3_flags0", 32'(bus.out_flags), 32'b00010);
    drive(0, 32'h0, 0, 1);
    chk("t3_flags1", 32'(bus.out_flags), 32'b00100);
    drive(0, 32'h0, 0, 1);
    chk("t3_flags2", 32'(bus.out_flags), 32'b01000);
    drive(0, 32'h0, 0, 1);
    chk("t3_flags3", 32'(bus.out_flags), 32'b10001);
    drive(0, 32'h0, 0, 1);
    chk("t3_exc_count", 32'(exc_count), 32'd1);

    // 4: fill, overflow, pop from full blocks the push, drain in order
    t4 = '{32'h3E800000, 32'h40200000, 32'h41C8FF1E, 32'hBFC74B5A, 32'h3FA00000};
    for (int i = 0; i < 4; i++) drive(1, t4[i], 0, 0);
    chk("t4_in_ready_full", 32'(bus.in_ready), 32'd0);
    drive(1, t4[4], 0, 0);
    chk("t4_overflow", 32'(overflow), 32'd1);
    chk("t4_count_full", 32'(count), 32'd4);
    chk("t4_head0", bus.out_data, t4[0]);
    drive(1, 32'h11111111, 0, 1);
    chk("t4_count_pop_full", 32'(count), 32'd3);
    for (int i = 1; i < 4; i++) begin
      chk($sformatf("t4_head%0d", i), bus.out_data, t4[i]);
      drive(0, 32'h0, 0, 1);
    end
    chk("t4_empty", 32'(bus.out_valid), 32'd0);
    step();
    chk("t4_ovf_sticky", 32'(overflow), 32'd1);
    clear_stats = 1'b1;
    step();
    clear_stats = 1'b0;
    chk("t4_ovf_cleared", 32'(overflow), 32'd0);

    // 5: simultaneous push and pop at count=2
    drive(1, 32'hC0000000, 0, 0);
    drive(1, 32'hC0400000, 0, 0);
    drive(1, 32'hC0800000, 0, 1);
    chk("t5_count", 32'(count), 32'd2);
    chk("t5_head", bus.out_data, 32'hC0400000);
    chk("t5_ovf", 32'(overflow), 32'd0);
    drive(0, 32'h0, 0, 1);
    chk("t5_head2", bus.out_data, 32'hC0800000);
    drive(0, 32'h0, 0, 1);

    // 6: exception counter saturation and clear-wins
    for (int i = 0; i < 4; i++) drive(1, 32'h3F800000 + 32'(i), 1, 1);
    chk("t6_exc_sat", 32'(exc_count), 32'd3);
    clear_stats = 1'b1;
    drive(1, 32'h44444444, 1, 0);
    clear_stats = 1'b0;
    chk("t6_exc_clear", 32'(exc_count), 32'd0);
    chk("t6_count", 32'(count), 32'd2);
    drive(0, 32'h0, 0, 1);
    chk("t6_queued", bus.out_data, 32'h44444444);
    drive(0, 32'h0, 0, 1);
    step();

    cmp_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
